uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter with an integrated TX FIFO. It replaces the fixed 8N1 transmitter in the peripheral bus UART. Software programs the baud divisor, the data length (5-8 bits), the parity mode and the stop-bit count. Bytes are pushed into the FIFO and serialised back-to-back, LSB first, with no idle gap between frames.

Parameters:
CLK_FREQ, 80_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, default baud rate, used when i_div < 2.
FIFO_DEPTH, 16, number of TX FIFO entries; must be a power of 2 and at least 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_wr_en  in  1  push i_wr_data into the FIFO
i_wr_data  in  8  byte to transmit
i_div  in  16  clock cycles per bit; values 0 and 1 select DEFAULT_DIV
i_data_bits  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits
i_parity  in  2  0=none, 1=even, 2=odd, 3=none
i_stop2  in  1  1 selects two stop bits, 0 selects one
o_tx_out  out  1  serial line, idle high, registered
o_tx_done  out  1  one-cycle pulse at the end of each frame
o_tx_busy  out  1  high whenever state != IDLE
o_full  out  1  FIFO full
o_empty  out  1  FIFO empty
o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_overflow  out  1  one-cycle pulse when a write is dropped
o_state_debug  out  3  current FSM state encoding

Behaviour:
- Reset values: o_tx_out=1; o_tx_done, o_tx_busy, o_full, o_overflow, o_level=0; o_empty=1; o_state_debug=0. FIFO pointers clear; stored contents are discarded.
- DEFAULT_DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, which is 694 at the defaults. eff_div = (i_div < 2) ? DEFAULT_DIV : i_div. The bit counter is 16 bits wide.
- FIFO write: accepted iff i_wr_en && !o_full, with o_full taken as registered at that edge. This holds even if a pop happens on the same cycle; in that case the write is dropped and o_overflow pulses. Status outputs are registered and update on the edge after the push or pop.
- States and o_state_debug encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Frame launch: in IDLE with !o_empty, the head entry is popped on that edge. On the same edge the block latches the byte, eff_div, data length, parity mode and stop count into frame registers, clears the counter, sets state=START and drives o_tx_out<=0. Config input changes mid-frame have no effect.
- Bit timing: every bit lasts exactly eff_div cycles. The counter runs 0..eff_div-1; the state or bit advances on the edge where counter==eff_div-1, and o_tx_out takes the next bit's value on that same edge.
- START -> DATA. DATA sends bits 0..N-1, N=5+data_bits, shifting out shift_reg[bit_index]. After bit N-1 the FSM goes to PARITY if parity is even or odd, otherwise to STOP.
- Parity bit: even = XOR of the N transmitted bits; odd = inverse of that. Unused upper byte bits are excluded.
- STOP: drives 1 for eff_div cycles, or 2*eff_div if i_stop2. At the final stop-bit edge, o_tx_done pulses for one cycle. If the FIFO is non-empty, the next frame launches on that same edge (pop, latch, START, o_tx_out<=0), giving zero idle gap. Otherwise state=IDLE and o_tx_out stays 1.
- o_tx_busy = (state != IDLE), combinational from the state register.
- Reset mid-frame: o_tx_out returns to 1 on the reset edge, the FSM goes to IDLE and the FIFO empties. No o_tx_done is issued.
- Undefined state encodings recover to IDLE with o_tx_out=1.

Test Plan:
- Reset, then i_div=4, 8N1 (data_bits=3, parity=0, stop2=0), write 0xA5 -> line low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. o_tx_done pulses once, 40 cycles after the pop.
- i_div=4, 7E2 (data_bits=2, parity=1, stop2=1), write 0x83 -> 7 data bits 1,1,0,0,0,0,0, then parity 0, then 8 high cycles. Frame length 11 bits = 44 cycles. Repeat with odd parity -> parity bit 1.
- i_div=0 -> every bit is 694 cycles, measured on the start bit.
- Write 17 bytes in consecutive cycles with FIFO_DEPTH=16 and the line idle -> first byte is popped, o_level peaks at 16, o_full asserts. Last write pulses o_overflow only if o_full was set. All accepted bytes go out back-to-back with no gap between stop and start; the o_tx_done count equals the number of accepted bytes.
- Assert i_rst halfway through DATA -> o_tx_out=1 on the next cycle, o_state_debug=0, o_empty=1, no o_tx_done. A new write afterwards transmits correctly.
- Change i_data_bits and i_div mid-frame -> current frame is unaffected; the next frame uses the new values.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/even/odd parity,
// one or two stop bits, fed from a TX FIFO and serialised back-to-back, LSB first.
module uart_tx_cfg #(
    parameter int unsigned CLK_FREQ   = 80_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [7:0]                  i_wr_data,
    input  logic [15:0]                 i_div,
    input  logic [1:0]                  i_data_bits,
    input  logic [1:0]                  i_parity,
    input  logic                        i_stop2,
    output logic                        o_tx_out,
    output logic                        o_tx_done,
    output logic                        o_tx_busy,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow,
    output logic [2:0]                  o_state_debug
);
    localparam int unsigned   AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned   LW          = AW + 1;
    localparam logic [15:0]   DEFAULT_DIV = 16'((CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE);
    localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // TX FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          full_q;
    logic          empty_q;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // Frame engine
    state_e        state_q;
    logic          tx_q;
    logic          done_q;
    logic [15:0]   cnt_q;
    logic [15:0]   div_q;
    logic [7:0]    shift_q;
    logic [2:0]    last_idx_q;
    logic [2:0]    bit_idx_q;
    logic          par_en_q;
    logic          par_odd_q;
    logic          stop2_q;

    logic [15:0]   eff_div;
    logic          bit_end;
    logic          last_stop;
    logic          frame_end;
    logic [7:0]    data_mask;
    logic          par_bit;

    assign eff_div   = (i_div < 16'd2) ? DEFAULT_DIV : i_div;
    assign bit_end   = (cnt_q == div_q - 16'd1);
    assign last_stop = (bit_idx_q == {2'b00, stop2_q});
    assign frame_end = (state_q == S_STOP) && bit_end && last_stop;
    assign data_mask = 8'hFF >> (3'd7 - last_idx_q);
    assign par_bit   = (^(shift_q & data_mask)) ^ par_odd_q;

    // A full FIFO rejects a write even when a pop frees a slot on the same edge.
    assign push = i_wr_en && !full_q;
    assign pop  = !empty_q && ((state_q == S_IDLE) || frame_end);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LEVEL_FULL);
            empty_q <= (level_d == '0);
            ovf_q   <= i_wr_en && full_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            div_q      <= '0;
            shift_q    <= '0;
            last_idx_q <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_q + 16'd1;
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        state_q   <= S_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == last_idx_q) begin
                            bit_idx_q <= '0;
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[bit_idx_q + 3'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        state_q   <= S_STOP;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (last_stop) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase

            // Launch overrides the case above: from IDLE, or on the final stop
            // edge so the next start bit follows with no idle gap.
            if (pop) begin
                shift_q    <= head;
                div_q      <= eff_div;
                last_idx_q <= {1'b1, i_data_bits};
                par_en_q   <= ^i_parity;
                par_odd_q  <= (i_parity == 2'd2);
                stop2_q    <= i_stop2;
                cnt_q      <= '0;
                state_q    <= S_START;
                tx_q       <= 1'b0;
            end
        end
    end

    assign o_tx_out      = tx_q;
    assign o_tx_done     = done_q;
    assign o_tx_busy     = (state_q != S_IDLE);
    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_level       = level_q;
    assign o_overflow    = ovf_q;
    assign o_state_debug = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table of frame vectors, a serial-line
// monitor fed by a scoreboard queue, and hand-written FIFO/reset/config sequences.
module tb_uart_tx_cfg;
    localparam int unsigned DEF_DIV = (80_000_000 + 115200 / 2) / 115200;

    logic        i_clk;
    logic        i_rst;
    logic        i_wr_en;
    logic [7:0]  i_wr_data;
    logic [15:0] i_div;
    logic [1:0]  i_data_bits;
    logic [1:0]  i_parity;
    logic        i_stop2;
    logic        o_tx_out;
    logic        o_tx_done;
    logic        o_tx_busy;
    logic        o_full;
    logic        o_empty;
    logic [4:0]  o_level;
    logic        o_overflow;
    logic [2:0]  o_state_debug;

    uart_tx_cfg #(
        .CLK_FREQ  (80_000_000),
        .BAUD_RATE (115200),
        .FIFO_DEPTH(16)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_en      (i_wr_en),
        .i_wr_data    (i_wr_data),
        .i_div        (i_div),
        .i_data_bits  (i_data_bits),
        .i_parity     (i_parity),
        .i_stop2      (i_stop2),
        .o_tx_out     (o_tx_out),
        .o_tx_done    (o_tx_done),
        .o_tx_busy    (o_tx_busy),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .o_state_debug(o_state_debug)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dbits;
        logic [1:0]  par;
        logic        stop2;
        int unsigned div;
    } frm_t;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dbits;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] div;
        int unsigned exp_cycles;
        int unsigned exp_start;
        logic        exp_par;
    } vec_t;

    frm_t        sb[$];
    vec_t        tbl[8];
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned gap0 = 0;
    logic        last_par = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge i_clk) cyc++;
    always @(negedge i_clk) if (o_tx_done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned eff(input logic [15:0] d);
        return (d < 16'd2) ? DEF_DIV : int'(d);
    endfunction

    task automatic set_cfg(input logic [15:0] d, input logic [1:0] db, input logic [1:0] p, input logic s2);
        i_div       = d;
        i_data_bits = db;
        i_parity    = p;
        i_stop2     = s2;
    endtask

    // Called at a falling edge; one-cycle write, expected frame queued with current config.
    task automatic send(input logic [7:0] d);
        frm_t f;
        f.data  = d;
        f.dbits = i_data_bits;
        f.par   = i_parity;
        f.stop2 = i_stop2;
        f.div   = eff(i_div);
        sb.push_back(f);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        @(negedge i_clk);
        i_wr_en   = 1'b0;
    endtask

    task automatic wait_low(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            @(negedge i_clk);
            if (o_tx_out === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            @(negedge i_clk);
            if (o_tx_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            @(negedge i_clk);
            if (o_state_debug === s) ok = 1'b1;
        end
    endtask

    // Serial-line monitor: every cycle of every bit must hold the expected level.
    initial begin : mon_blk
        bit          have;
        bit          stable;
        bit          aborted;
        frm_t        f;
        logic [11:0] ebits;
        logic        first;
        logic        p;
        int unsigned n;
        int unsigned nb;
        int          par_idx;
        have = 1'b0;
        forever begin
            if (!have) @(negedge i_clk);
            have = 1'b0;
            if (mon_en && o_tx_out === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("sb_has_frame", 32'd0, 32'd1);
                end else begin
                    f       = sb.pop_front();
                    n       = 5 + int'(f.dbits);
                    ebits   = '1;
                    ebits[0] = 1'b0;
                    p       = (f.par == 2'd2);
                    for (int unsigned i = 0; i < n; i++) begin
                        ebits[1 + i] = f.data[i];
                        p = p ^ f.data[i];
                    end
                    nb      = 1 + n;
                    par_idx = -1;
                    if (f.par == 2'd1 || f.par == 2'd2) begin
                        ebits[nb] = p;
                        par_idx   = int'(nb);
                        nb++;
                    end
                    nb = nb + (f.stop2 ? 2 : 1);
                    aborted = 1'b0;
                    first   = 1'b0;
                    for (int unsigned b = 0; b < nb && !aborted; b++) begin
                        stable = 1'b1;
                        for (int unsigned c = 0; c < f.div; c++) begin
                            if (!(b == 0 && c == 0)) begin
                                @(negedge i_clk);
                                if (!mon_en) begin
                                    aborted = 1'b1;
                                    break;
                                end
                                if (o_tx_done !== 1'b0) stable = 1'b0;
                            end
                            if (c == 0) first = o_tx_out;
                            else if (o_tx_out !== first) stable = 1'b0;
                        end
                        if (!aborted) begin
                            chk("frame_bit", {30'd0, stable, first}, {30'd0, 1'b1, ebits[b]});
                            if (int'(b) == par_idx) last_par = first;
                        end
                    end
                    if (!aborted) begin
                        @(negedge i_clk);
                        if (mon_en) begin
                            chk("tx_done_pulse", {31'd0, o_tx_done}, 32'd1);
                            if (o_tx_out === 1'b0) begin
                                gap0++;
                                have = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main_blk
        bit          ok;
        int unsigned t0;
        int unsigned t1;
        int unsigned n;
        int unsigned base_done;
        int unsigned base_gap;

        // data, dbits, parity, stop2, div, frame cycles, start-bit cycles (0 = skip), parity bit
        tbl[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 16'd4,   40,   4, 1'b0};
        tbl[1] = '{8'h83, 2'd2, 2'd1, 1'b1, 16'd4,   44,   4, 1'b0};
        tbl[2] = '{8'h83, 2'd2, 2'd2, 1'b1, 16'd4,   44,   4, 1'b1};
        tbl[3] = '{8'h3A, 2'd0, 2'd3, 1'b0, 16'd3,   21,   0, 1'b0};
        tbl[4] = '{8'h41, 2'd1, 2'd1, 1'b0, 16'd5,   45,   5, 1'b1};
        tbl[5] = '{8'h00, 2'd3, 2'd2, 1'b1, 16'd2,   24,   0, 1'b1};
        tbl[6] = '{8'h15, 2'd0, 2'd0, 1'b0, 16'd0, 4858, 694, 1'b0};
        tbl[7] = '{8'h07, 2'd0, 2'd2, 1'b0, 16'd1, 5552, 694, 1'b0};

        i_rst     = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_data = 8'h00;
        set_cfg(16'd4, 2'd3, 2'd0, 1'b0);
        repeat (2) @(negedge i_clk);
        chk("rst_tx_out", {31'd0, o_tx_out}, 32'd1);
        chk("rst_tx_done", {31'd0, o_tx_done}, 32'd0);
        chk("rst_busy", {31'd0, o_tx_busy}, 32'd0);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        chk("rst_level", {27'd0, o_level}, 32'd0);
        chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
        chk("rst_state", {29'd0, o_state_debug}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        mon_en = 1'b1;

        for (int k = 0; k < 8; k++) begin
            set_cfg(tbl[k].div, tbl[k].dbits, tbl[k].par, tbl[k].stop2);
            send(tbl[k].data);
            wait_low(10, ok);
            chk("start_seen", {31'd0, ok}, 32'd1);
            t0 = cyc;
            if (ok && tbl[k].exp_start != 0) begin
                n = 1;
                for (int unsigned i = 0; i < 1000; i++) begin
                    @(negedge i_clk);
                    if (o_tx_out !== 1'b0) break;
                    n++;
                end
                chk("start_len", n, tbl[k].exp_start);
            end
            wait_done(tbl[k].exp_cycles + 10, ok);
            chk("done_seen", {31'd0, ok}, 32'd1);
            t1 = cyc;
            if (ok) chk("frame_len", t1 - t0, tbl[k].exp_cycles);
            if (tbl[k].par == 2'd1 || tbl[k].par == 2'd2)
                chk("parity_bit", {31'd0, last_par}, {31'd0, tbl[k].exp_par});
            chk("idle_state", {29'd0, o_state_debug}, 32'd0);
            chk("idle_busy", {31'd0, o_tx_busy}, 32'd0);
        end

        // Mid-frame config change: running frame keeps 8N1/div4, queued one gets 5O2/div6.
        set_cfg(16'd4, 2'd3, 2'd0, 1'b0);
        send(8'h96);
        wait_state(3'd2, 20, ok);
        chk("cfg_in_data", {31'd0, ok}, 32'd1);
        chk("cfg_busy", {31'd0, o_tx_busy}, 32'd1);
        set_cfg(16'd6, 2'd0, 2'd2, 1'b1);
        send(8'h0D);
        wait_done(60, ok);
        chk("cfg_done1", {31'd0, ok}, 32'd1);
        chk("cfg_b2b_start", {31'd0, o_tx_out}, 32'd0);
        t0 = cyc;
        wait_done(80, ok);
        chk("cfg_done2", {31'd0, ok}, 32'd1);
        t1 = cyc;
        if (ok) chk("cfg_frame_len", t1 - t0, 32'd54);
        chk("cfg_parity", {31'd0, last_par}, 32'd0);

        // Burst of 18 writes: first is popped at once, 16 fill the FIFO, the 18th is dropped.
        set_cfg(16'd4, 2'd3, 2'd0, 1'b0);
        repeat (3) @(negedge i_clk);
        base_done = done_cnt;
        base_gap  = gap0;
        for (int k = 0; k < 18; k++) begin
            if (k < 17) begin
                frm_t f;
                f.data  = 8'h10 + 8'(k);
                f.dbits = 2'd3;
                f.par   = 2'd0;
                f.stop2 = 1'b0;
                f.div   = 4;
                sb.push_back(f);
            end
            i_wr_en   = 1'b1;
            i_wr_data = 8'h10 + 8'(k);
            @(negedge i_clk);
            chk("burst_overflow", {31'd0, o_overflow}, (k == 17) ? 32'd1 : 32'd0);
            if (k == 15) begin
                chk("burst_level15", {27'd0, o_level}, 32'd15);
                chk("burst_notfull15", {31'd0, o_full}, 32'd0);
            end
            if (k >= 16) begin
                chk("burst_level_peak", {27'd0, o_level}, 32'd16);
                chk("burst_full", {31'd0, o_full}, 32'd1);
            end
        end
        i_wr_en = 1'b0;
        for (int unsigned i = 0; i < 760 && done_cnt < base_done + 17; i++) @(negedge i_clk);
        repeat (50) @(negedge i_clk);
        chk("burst_done_count", done_cnt - base_done, 32'd17);
        chk("burst_zero_gaps", gap0 - base_gap, 32'd16);
        chk("burst_empty", {31'd0, o_empty}, 32'd1);
        chk("burst_level0", {27'd0, o_level}, 32'd0);

        // Reset in the middle of DATA with a second byte still queued.
        set_cfg(16'd4, 2'd3, 2'd0, 1'b0);
        send(8'h3C);
        send(8'h11);
        wait_state(3'd2, 20, ok);
        chk("rst_mid_in_data", {31'd0, ok}, 32'd1);
        repeat (4) @(negedge i_clk);
        mon_en    = 1'b0;
        i_rst     = 1'b1;
        base_done = done_cnt;
        @(negedge i_clk);
        chk("midrst_tx_out", {31'd0, o_tx_out}, 32'd1);
        chk("midrst_state", {29'd0, o_state_debug}, 32'd0);
        chk("midrst_empty", {31'd0, o_empty}, 32'd1);
        chk("midrst_busy", {31'd0, o_tx_busy}, 32'd0);
        i_rst = 1'b0;
        sb.delete();
        repeat (60) @(negedge i_clk);
        chk("midrst_no_done", done_cnt - base_done, 32'd0);
        chk("midrst_line_idle", {31'd0, o_tx_out}, 32'd1);
        mon_en = 1'b1;
        send(8'h5A);
        wait_done(60, ok);
        chk("post_rst_done", {31'd0, ok}, 32'd1);
        repeat (5) @(negedge i_clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
